// File: rtl/mcs4_pkg.sv
// Shared encodings for the MCS-4 clock sequencer: subcycle numbers, quarter
// decode values and sequencer FSM states.
package mcs4_pkg;

    localparam logic [2:0] SC_A1 = 3'd0;
    localparam logic [2:0] SC_A2 = 3'd1;
    localparam logic [2:0] SC_A3 = 3'd2;
    localparam logic [2:0] SC_M1 = 3'd3;
    localparam logic [2:0] SC_M2 = 3'd4;
    localparam logic [2:0] SC_X1 = 3'd5;
    localparam logic [2:0] SC_X2 = 3'd6;
    localparam logic [2:0] SC_X3 = 3'd7;

    // Quarter-subcycle decode: clk1 high, gap, clk2 high, gap
    localparam logic [1:0] Q_CLK1 = 2'd0;
    localparam logic [1:0] Q_GAP1 = 2'd1;
    localparam logic [1:0] Q_CLK2 = 2'd2;
    localparam logic [1:0] Q_GAP2 = 2'd3;

    localparam int unsigned TICK_W   = 8;
    localparam int unsigned POC_W    = 8;
    localparam int unsigned CCOUNT_W = 32;

    typedef enum logic [1:0] {
        ST_POC  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mcs4_clock_sequencer_if.sv
// Control/observation bundle of the MCS-4 clock sequencer.
// Optional MCS4_CYCLE_COUNT_EN adds count_clr and cycle_count.
interface mcs4_clock_sequencer_if;

    logic       run;
    logic       step;
    logic       clk1_pad;
    logic       clk2_pad;
    logic       poc_pad;
    logic [2:0] subcycle;
    logic       sync_exp;
    logic       cycle_start;
    logic       halted;
`ifdef MCS4_CYCLE_COUNT_EN
    logic        count_clr;
    logic [31:0] cycle_count;

    modport slave (
        input  run, step, count_clr,
        output clk1_pad, clk2_pad, poc_pad, subcycle, sync_exp, cycle_start, halted, cycle_count
    );
    modport master (
        output run, step, count_clr,
        input  clk1_pad, clk2_pad, poc_pad, subcycle, sync_exp, cycle_start, halted, cycle_count
    );
`else
    modport slave (
        input  run, step,
        output clk1_pad, clk2_pad, poc_pad, subcycle, sync_exp, cycle_start, halted
    );
    modport master (
        output run, step,
        input  clk1_pad, clk2_pad, poc_pad, subcycle, sync_exp, cycle_start, halted
    );
`endif

endinterface

// File: rtl/mcs4_phase_counter.sv
// Tick / quarter / subcycle position counter for one MCS-4 instruction cycle.
// Advances only when en_i is high; reports first and last position of the cycle.
module mcs4_phase_counter
    import mcs4_pkg::*;
#(
    parameter int unsigned PHASE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [1:0] quarter_o,
    output logic [2:0] subcycle_o,
    output logic       at_start_o,
    output logic       at_last_o
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);

    logic [TICK_W-1:0] tick_q;
    logic [1:0]        quarter_q;
    logic [2:0]        subcycle_q;
    logic              tick_last;
    logic              quarter_last;

    assign tick_last    = (tick_q == TICK_LAST);
    assign quarter_last = (quarter_q == Q_GAP2);

    // Nested wrap: tick -> quarter -> subcycle, wrapping X3 back to A1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q     <= '0;
            quarter_q  <= Q_CLK1;
            subcycle_q <= SC_A1;
        end else if (en_i) begin
            if (tick_last) begin
                tick_q    <= '0;
                quarter_q <= quarter_q + 2'd1;
                if (quarter_last) begin
                    subcycle_q <= subcycle_q + 3'd1;
                end
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

    assign quarter_o  = quarter_q;
    assign subcycle_o = subcycle_q;
    assign at_start_o = (tick_q == '0) && (quarter_q == Q_CLK1) && (subcycle_q == SC_A1);
    assign at_last_o  = tick_last && quarter_last && (subcycle_q == SC_X3);

endmodule

// File: rtl/mcs4_clock_sequencer.sv
// MCS-4 two-phase clock, power-on-clear and instruction-cycle tracker with
// run/halt/single-step control. Optional macro: MCS4_CYCLE_COUNT_EN.
module mcs4_clock_sequencer
    import mcs4_pkg::*;
#(
    parameter int unsigned PHASE_TICKS = 4,
    parameter int unsigned POC_CYCLES  = 8
) (
    input  logic                   sysclk,
    input  logic                   rst_n,
    mcs4_clock_sequencer_if.slave  bus
);

    seq_state_e       state_q, state_d;
    logic             exec_c;
    logic [POC_W-1:0] poc_cnt_q;
    logic             poc_done;

    logic [1:0] quarter;
    logic [2:0] subcycle;
    logic       at_start;
    logic       at_last;

    logic       clk1_q, clk2_q, poc_q, sync_q, cstart_q, halted_q;
    logic [2:0] subcycle_q;

    mcs4_phase_counter #(
        .PHASE_TICKS (PHASE_TICKS)
    ) u_phase (
        .clk        (sysclk),
        .rst_n      (rst_n),
        .en_i       (exec_c),
        .quarter_o  (quarter),
        .subcycle_o (subcycle),
        .at_start_o (at_start),
        .at_last_o  (at_last)
    );

    assign poc_done = (poc_cnt_q == POC_W'(POC_CYCLES));

    // exec_c: this edge emits the position held in the counter and advances it
    always_comb begin
        state_d = state_q;
        exec_c  = 1'b1;
        unique case (state_q)
            ST_POC: begin
                if (at_start && poc_done) begin
                    exec_c  = bus.run;
                    state_d = bus.run ? ST_RUN : ST_HALT;
                end
            end
            ST_RUN: begin
                if (at_start && !bus.run) begin
                    exec_c  = 1'b0;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                exec_c = 1'b0;
                if (bus.run) begin
                    state_d = ST_RUN;
                end else if (bus.step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (at_last) begin
                    state_d = bus.run ? ST_RUN : ST_HALT;
                end
            end
            default: begin
                exec_c  = 1'b0;
                state_d = ST_POC;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_POC;
            poc_cnt_q  <= '0;
            clk1_q     <= 1'b0;
            clk2_q     <= 1'b0;
            poc_q      <= 1'b1;
            sync_q     <= 1'b0;
            cstart_q   <= 1'b0;
            halted_q   <= 1'b0;
            subcycle_q <= SC_A1;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_POC) && exec_c && at_last) begin
                poc_cnt_q <= poc_cnt_q + POC_W'(1);
            end
            if ((state_q == ST_POC) && (state_d != ST_POC)) begin
                poc_q <= 1'b0;
            end
            clk1_q     <= exec_c && (quarter == Q_CLK1);
            clk2_q     <= exec_c && (quarter == Q_CLK2);
            sync_q     <= exec_c && (subcycle == SC_X3);
            cstart_q   <= exec_c && at_start;
            subcycle_q <= exec_c ? subcycle : SC_A1;
            halted_q   <= (state_d == ST_HALT) && !exec_c;
        end
    end

    assign bus.clk1_pad    = clk1_q;
    assign bus.clk2_pad    = clk2_q;
    assign bus.poc_pad     = poc_q;
    assign bus.sync_exp    = sync_q;
    assign bus.cycle_start = cstart_q;
    assign bus.halted      = halted_q;
    assign bus.subcycle    = subcycle_q;

`ifdef MCS4_CYCLE_COUNT_EN
    logic [CCOUNT_W-1:0] ccount_q;

    // Clear wins over a coinciding cycle_start
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ccount_q <= '0;
        end else if (bus.count_clr) begin
            ccount_q <= '0;
        end else if (exec_c && at_start) begin
            ccount_q <= ccount_q + CCOUNT_W'(1);
        end
    end

    assign bus.cycle_count = ccount_q;
`endif

endmodule

// File: tb/tb_mcs4_clock_sequencer.sv
// Randomized self-checking bench for mcs4_clock_sequencer against a
// position-arithmetic reference model plus directed timing checks.
module tb_mcs4_clock_sequencer;

    localparam int PT    = 4;
    localparam int POC_N = 2;
    localparam int CYC   = 32 * PT;

    localparam int M_POC  = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_STEP = 3;

    localparam logic [8:0] RST_VEC = 9'b1_00000_000;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b1;

    always #5 sysclk = ~sysclk;

    mcs4_clock_sequencer_if bus ();

    mcs4_clock_sequencer #(
        .PHASE_TICKS (PT),
        .POC_CYCLES  (POC_N)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode plus a single linear position within the cycle
    int          m_mode;
    int          m_pos;
    int          m_done;
    logic        m_poc;
    int unsigned m_count;

    task automatic model_reset();
        m_mode  = M_POC;
        m_pos   = 0;
        m_done  = 0;
        m_poc   = 1'b1;
        m_count = 0;
    endtask

    function automatic logic [8:0] dut_vec();
        return {bus.poc_pad, bus.clk1_pad, bus.clk2_pad, bus.sync_exp,
                bus.cycle_start, bus.halted, bus.subcycle};
    endfunction

    int   edge_no, cs_cnt, last_cs_edge, cs_gap, clk1_rises;
    int   clk2_first_edge, poc_fall_edge, sync_rise_edge, halt_edge;
    logic prev_clk1, prev_clk2, prev_poc, prev_sync, prev_halted;

    task automatic clear_trk();
        edge_no         = 0;
        cs_cnt          = 0;
        last_cs_edge    = -1;
        cs_gap          = 0;
        clk1_rises      = 0;
        clk2_first_edge = -1;
        poc_fall_edge   = -1;
        sync_rise_edge  = -1;
        halt_edge       = -1;
        prev_clk1       = bus.clk1_pad;
        prev_clk2       = bus.clk2_pad;
        prev_poc        = bus.poc_pad;
        prev_sync       = bus.sync_exp;
        prev_halted     = bus.halted;
    endtask

    task automatic clk_edge();
        bit         ex;
        logic       e_clk1, e_clk2, e_sync, e_cs, e_halted;
        int         e_sc;
        logic [8:0] ev;
        @(posedge sysclk);
        ex = 1'b0;
        case (m_mode)
            M_POC: begin
                if (m_pos == 0 && m_done == POC_N) begin
                    m_poc  = 1'b0;
                    m_mode = bus.run ? M_RUN : M_HALT;
                    ex     = bus.run;
                end else begin
                    ex = 1'b1;
                end
            end
            M_RUN: begin
                if (m_pos == 0 && !bus.run) m_mode = M_HALT;
                else ex = 1'b1;
            end
            M_HALT: begin
                if (bus.run) m_mode = M_RUN;
                else if (bus.step) m_mode = M_STEP;
            end
            default: ex = 1'b1;
        endcase
        e_clk1 = 1'b0; e_clk2 = 1'b0; e_sync = 1'b0; e_cs = 1'b0; e_sc = 0;
        if (ex) begin
            e_clk1 = ((m_pos / PT) % 4) == 0;
            e_clk2 = ((m_pos / PT) % 4) == 2;
            e_sc   = m_pos / (4 * PT);
            e_sync = (e_sc == 7);
            e_cs   = (m_pos == 0);
            m_pos++;
            if (m_pos == CYC) begin
                m_pos = 0;
                if (m_mode == M_POC) m_done++;
                if (m_mode == M_STEP) m_mode = bus.run ? M_RUN : M_HALT;
            end
        end
`ifdef MCS4_CYCLE_COUNT_EN
        if (bus.count_clr) m_count = 0;
        else if (e_cs) m_count++;
`endif
        e_halted = (m_mode == M_HALT) && !ex;
        ev = {m_poc, e_clk1, e_clk2, e_sync, e_cs, e_halted, 3'(e_sc)};
        #1;
        edge_no++;
        chk("outs", 32'(dut_vec()), 32'(ev));
        chk("nonovl", 32'(bus.clk1_pad & bus.clk2_pad), 32'd0);
`ifdef MCS4_CYCLE_COUNT_EN
        chk("ccount", bus.cycle_count, m_count);
`endif
        if (bus.cycle_start) begin
            if (last_cs_edge >= 0) cs_gap = edge_no - last_cs_edge;
            last_cs_edge = edge_no;
            cs_cnt++;
        end
        if (bus.clk1_pad && !prev_clk1) clk1_rises++;
        if (bus.clk2_pad && !prev_clk2 && clk2_first_edge < 0) clk2_first_edge = edge_no;
        if (!bus.poc_pad && prev_poc) poc_fall_edge = edge_no;
        if (bus.sync_exp && !prev_sync && sync_rise_edge < 0) sync_rise_edge = edge_no;
        if (bus.halted && !prev_halted) halt_edge = edge_no;
        prev_clk1   = bus.clk1_pad;
        prev_clk2   = bus.clk2_pad;
        prev_poc    = bus.poc_pad;
        prev_sync   = bus.sync_exp;
        prev_halted = bus.halted;
    endtask

    task automatic rst_edge();
        @(posedge sysclk);
        #1;
        chk("rst_hold", 32'(dut_vec()), 32'(RST_VEC));
    endtask

    initial begin
        bit found;
        bus.run  = 1'b1;
        bus.step = 1'b0;
`ifdef MCS4_CYCLE_COUNT_EN
        bus.count_clr = 1'b0;
`endif
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) rst_edge();

        // Power-on sequence with run held high
        rst_n = 1'b1;
        clear_trk();
        repeat (400) clk_edge();
        chk("poc_fall", 32'(poc_fall_edge), 32'd257);
        chk("cs_cnt", 32'(cs_cnt), 32'd4);
        chk("cs_last", 32'(last_cs_edge), 32'd385);
        chk("cs_gap", 32'(cs_gap), 32'd128);
        chk("sync_rise", 32'(sync_rise_edge), 32'd113);
        chk("clk2_first", 32'(clk2_first_edge), 32'd9);

        // Drop run during M2, expect halt at the next boundary
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clk_edge();
            if (bus.subcycle == 3'd4) begin found = 1'b1; break; end
        end
        chk("wait_m2", 32'(found), 32'd1);
        bus.run = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            clk_edge();
            if (bus.halted) begin found = 1'b1; break; end
        end
        chk("wait_halt", 32'(found), 32'd1);
        chk("halt_sc", 32'(bus.subcycle), 32'd0);
        chk("halt_clk", 32'({bus.clk1_pad, bus.clk2_pad}), 32'd0);
        cs_cnt = 0;
        repeat (60) clk_edge();
        chk("halt_nocs", 32'(cs_cnt), 32'd0);

        // Single step, with a second step pulse inside the stepped cycle
        cs_cnt     = 0;
        clk1_rises = 0;
        bus.step   = 1'b1;
        clk_edge();
        bus.step = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            clk_edge();
            if (bus.halted) begin found = 1'b1; break; end
            bus.step = (i == 20);
        end
        bus.step = 1'b0;
        chk("step_to", 32'(found), 32'd1);
        chk("step_cs", 32'(cs_cnt), 32'd1);
        chk("step_clk1", 32'(clk1_rises), 32'd8);
        chk("step_len", 32'(halt_edge - last_cs_edge), 32'd128);
        repeat (200) clk_edge();
        chk("step_noq", 32'(cs_cnt), 32'd1);

        // run and step together from HALT
        bus.run  = 1'b1;
        bus.step = 1'b1;
        clk_edge();
        bus.step     = 1'b0;
        cs_cnt       = 0;
        last_cs_edge = -1;
        cs_gap       = 0;
        repeat (400) clk_edge();
        chk("rs_cs", 32'(cs_cnt), 32'd4);
        chk("rs_gap", 32'(cs_gap), 32'd128);

        // Random run toggles and step pulses
        for (int i = 0; i < 3000; i++) begin
            clk_edge();
            if ($urandom_range(0, 299) == 0) bus.run = ~bus.run;
            bus.step = ($urandom_range(0, 39) == 0);
`ifdef MCS4_CYCLE_COUNT_EN
            bus.count_clr = ($urandom_range(0, 99) == 0);
`endif
        end
        bus.step = 1'b0;
`ifdef MCS4_CYCLE_COUNT_EN
        bus.count_clr = 1'b0;
`endif

        // Asynchronous reset in the middle of X1
        bus.run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            clk_edge();
            if (bus.subcycle == 3'd5 && !bus.halted) begin found = 1'b1; break; end
        end
        chk("wait_x1", 32'(found), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst", 32'(dut_vec()), 32'(RST_VEC));
`ifdef MCS4_CYCLE_COUNT_EN
        chk("arst_cc", bus.cycle_count, 32'd0);
`endif
        model_reset();
        repeat (2) rst_edge();
        rst_n = 1'b1;
        clear_trk();
        repeat (300) clk_edge();
        chk("poc2_fall", 32'(poc_fall_edge), 32'd257);
        chk("poc2_cs", 32'(cs_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
